// File: rtl/dmi_resp_ctrl_pkg.sv
// Shared DMI types for the DTM <-> Debug Module sequencing controller.
// Holds the request/response formats, the captured status codes and the request FSM states.
package dmi_resp_ctrl_pkg;

  typedef enum logic [1:0] {
    DMI_NOP   = 2'd0,
    DMI_READ  = 2'd1,
    DMI_WRITE = 2'd2
  } dmi_op_e;

  typedef enum logic [1:0] {
    DTM_OK     = 2'd0,
    DTM_FAILED = 2'd2,
    DTM_BUSY   = 2'd3
  } dtm_op_e;

  typedef struct packed {
    logic [6:0]  addr;
    dmi_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } req_state_e;

endpackage

// File: rtl/dmi_resp_ctrl_if.sv
// Bundle of the DTM, Debug Module and response-FIFO signals around dmi_resp_ctrl.
// The slave modport is the controller's view; master is the surrounding DTM top.
interface dmi_resp_ctrl_if;
    import dmi_resp_ctrl_pkg::*;

    logic      dtm_req_valid_i;
    dmi_req_t  dtm_req_i;
    logic      dtm_capture_i;
    logic [1:0]  dtm_op_o;
    logic [31:0] dtm_data_o;
    logic      dm_req_valid_o;
    dmi_req_t  dm_req_o;
    logic      dm_req_ready_i;
    logic      dm_resp_valid_i;
    dmi_resp_t dm_resp_i;
    logic      dm_resp_ready_o;
    logic      resp_queue_push_o;
    dmi_resp_t resp_queue_inp_o;
    logic      resp_queue_pop_o;
    dmi_resp_t resp_queue_data_i;
    logic      resp_queue_full_i;
    logic      resp_queue_empty_i;

    modport slave (
        input  dtm_req_valid_i, dtm_req_i, dtm_capture_i,
        input  dm_req_ready_i, dm_resp_valid_i, dm_resp_i,
        input  resp_queue_data_i, resp_queue_full_i, resp_queue_empty_i,
        output dtm_op_o, dtm_data_o, dm_req_valid_o, dm_req_o, dm_resp_ready_o,
        output resp_queue_push_o, resp_queue_inp_o, resp_queue_pop_o
    );

    modport master (
        output dtm_req_valid_i, dtm_req_i, dtm_capture_i,
        output dm_req_ready_i, dm_resp_valid_i, dm_resp_i,
        output resp_queue_data_i, resp_queue_full_i, resp_queue_empty_i,
        input  dtm_op_o, dtm_data_o, dm_req_valid_o, dm_req_o, dm_resp_ready_o,
        input  resp_queue_push_o, resp_queue_inp_o, resp_queue_pop_o
    );

endinterface

// File: rtl/dmi_resp_ctrl.sv
// Forwards DTM requests to the Debug Module, pushes DM responses into the response FIFO,
// pops it on capture-DR and maintains the sticky busy/failed DMI status.
module dmi_resp_ctrl
    import dmi_resp_ctrl_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input logic           clk_i,
    input logic           rst_ni,
    input logic           dmi_rst_ni,
    dmi_resp_ctrl_if.slave bus
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    req_state_e    state_q, state_d;
    logic [CntW-1:0] count_q, count_d, count_popped;
    dtm_op_e       sticky_q, sticky_d;
    dtm_op_e       op_q, op_d;
    logic [31:0]   data_q, data_d;
    dmi_req_t      dm_req_q, dm_req_d;
    logic          pop, issue;

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            count_q  <= '0;
            sticky_q <= DTM_OK;
            op_q     <= DTM_OK;
            data_q   <= '0;
            dm_req_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
            op_q     <= op_d;
            data_q   <= data_d;
            dm_req_q <= dm_req_d;
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        sticky_d     = sticky_q;
        op_d         = op_q;
        data_d       = data_q;
        dm_req_d     = dm_req_q;
        pop          = 1'b0;
        issue        = 1'b0;
        count_popped = count_q;

        // Capture is resolved first so a request in the same cycle sees the updated sticky.
        if (bus.dtm_capture_i) begin
            if (!bus.resp_queue_empty_i) begin
                pop    = 1'b1;
                data_d = bus.resp_queue_data_i.data;
                if (sticky_q != DTM_OK)                       op_d = sticky_q;
                else if (bus.resp_queue_data_i.resp != 2'b00) op_d = DTM_FAILED;
                else                                          op_d = DTM_OK;
                if (bus.resp_queue_data_i.resp != 2'b00) sticky_d = DTM_FAILED;
            end else if (count_q != '0) begin
                op_d     = (sticky_q == DTM_FAILED) ? DTM_FAILED : DTM_BUSY;
                sticky_d = op_d;
            end else begin
                op_d = sticky_q;
            end
        end

        count_popped = count_q - CntW'(pop);

        if (bus.dtm_req_valid_i) begin
            if (state_q == IDLE && sticky_d == DTM_OK && count_popped < CntW'(MaxOutstanding)) begin
                issue    = 1'b1;
                dm_req_d = bus.dtm_req_i;
                state_d  = ISSUE;
            end else if (sticky_d != DTM_FAILED) begin
                sticky_d = DTM_BUSY;
            end
        end

        if (state_q == ISSUE && bus.dm_req_ready_i) state_d = IDLE;

        count_d = count_popped + CntW'(issue);

        // The DTM-side reset behaves like the power-on reset but takes effect on the edge.
        if (!dmi_rst_ni) begin
            state_d  = IDLE;
            count_d  = '0;
            sticky_d = DTM_OK;
            op_d     = DTM_OK;
            data_d   = '0;
            dm_req_d = '0;
            pop      = 1'b0;
            issue    = 1'b0;
        end
    end

    assign bus.dm_req_valid_o    = (state_q == ISSUE);
    assign bus.dm_req_o          = dm_req_q;
    assign bus.dtm_op_o          = op_q;
    assign bus.dtm_data_o        = data_q;
    assign bus.dm_resp_ready_o   = ~bus.resp_queue_full_i;
    assign bus.resp_queue_inp_o  = bus.dm_resp_i;
    assign bus.resp_queue_push_o = bus.dm_resp_valid_i & ~bus.resp_queue_full_i & rst_ni & dmi_rst_ni;
    assign bus.resp_queue_pop_o  = pop & rst_ni;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni || !dmi_rst_ni)
        !(issue && !pop && count_q == CntW'(MaxOutstanding)));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni || !dmi_rst_ni)
        !(pop && !issue && count_q == '0));

endmodule

// File: tb/tb_dmi_resp_ctrl.sv
// Directed bench for dmi_resp_ctrl with a small 2-deep response FIFO alongside the DUT.
// Expected values are hand-derived for each scenario.
module tb_dmi_resp_ctrl;
    import dmi_resp_ctrl_pkg::*;

    logic clk_i      = 1'b0;
    logic rst_ni     = 1'b0;
    logic dmi_rst_ni = 1'b1;
    int   errors     = 0;
    int   checks     = 0;
    int   hs         = 0;

    always #5 clk_i = ~clk_i;

    dmi_resp_ctrl_if bus ();

    dmi_resp_ctrl #(.MaxOutstanding(2)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .dmi_rst_ni (dmi_rst_ni),
        .bus        (bus)
    );

    // Response FIFO stand-in, flushed by the DTM-side reset.
    dmi_resp_t   fmem [2];
    logic        rd_ptr = 1'b0;
    logic        wr_ptr = 1'b0;
    int unsigned fcnt   = 0;

    assign bus.resp_queue_full_i  = (fcnt == 2);
    assign bus.resp_queue_empty_i = (fcnt == 0);
    assign bus.resp_queue_data_i  = fmem[rd_ptr];

    always @(posedge clk_i) begin
        if (!dmi_rst_ni) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            fcnt   <= 0;
        end else begin
            if (bus.resp_queue_push_o) begin
                fmem[wr_ptr] <= bus.resp_queue_inp_o;
                wr_ptr       <= ~wr_ptr;
            end
            if (bus.resp_queue_pop_o) rd_ptr <= ~rd_ptr;
            fcnt <= fcnt + int'(bus.resp_queue_push_o) - int'(bus.resp_queue_pop_o);
        end
    end

    always @(posedge clk_i)
        if (rst_ni && bus.dm_req_valid_o && bus.dm_req_ready_i) hs <= hs + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [6:0] a, input logic [31:0] d);
        bus.dtm_req_valid_i = 1'b1;
        bus.dtm_req_i       = '{addr: a, op: DMI_READ, data: d};
        step();
        bus.dtm_req_valid_i = 1'b0;
    endtask

    task automatic accept();
        bus.dm_req_ready_i = 1'b1;
        step();
        bus.dm_req_ready_i = 1'b0;
    endtask

    task automatic respond(input string tag, input logic [31:0] d, input logic [1:0] r);
        bus.dm_resp_valid_i = 1'b1;
        bus.dm_resp_i       = '{data: d, resp: r};
        #1;
        check({tag, ".push"}, 64'(bus.resp_queue_push_o), 64'd1);
        step();
        bus.dm_resp_valid_i = 1'b0;
    endtask

    task automatic capture(input string tag, input logic exp_pop,
                           input logic [1:0] exp_op, input logic [31:0] exp_data);
        bus.dtm_capture_i = 1'b1;
        #1;
        check({tag, ".pop"}, 64'(bus.resp_queue_pop_o), 64'(exp_pop));
        step();
        bus.dtm_capture_i = 1'b0;
        check({tag, ".op"}, 64'(bus.dtm_op_o), 64'(exp_op));
        check({tag, ".data"}, 64'(bus.dtm_data_o), 64'(exp_data));
    endtask

    task automatic dmi_reset();
        dmi_rst_ni = 1'b0;
        step();
        dmi_rst_ni = 1'b1;
    endtask

    initial begin
        bus.dtm_req_valid_i = 1'b0;
        bus.dtm_req_i       = '0;
        bus.dtm_capture_i   = 1'b0;
        bus.dm_req_ready_i  = 1'b0;
        bus.dm_resp_valid_i = 1'b0;
        bus.dm_resp_i       = '0;

        step();
        step();
        check("rst.valid", 64'(bus.dm_req_valid_o), 64'd0);
        check("rst.req",   64'(bus.dm_req_o), 64'd0);
        check("rst.op",    64'(bus.dtm_op_o), 64'd0);
        check("rst.pop",   64'(bus.resp_queue_pop_o), 64'd0);
        rst_ni = 1'b1;
        step();

        // Plain read of address 0x04.
        issue(7'h04, 32'h0);
        check("rd.valid", 64'(bus.dm_req_valid_o), 64'd1);
        check("rd.addr",  64'(bus.dm_req_o.addr), 64'h04);
        accept();
        check("rd.idle",  64'(bus.dm_req_valid_o), 64'd0);
        step();
        respond("rd.resp", 32'hDEADBEEF, 2'd0);
        capture("rd.cap", 1'b1, 2'd0, 32'hDEADBEEF);
        capture("rd.cap0", 1'b0, 2'd0, 32'hDEADBEEF);

        // Capture before the DM answers: busy is sticky until dmireset.
        issue(7'h10, 32'h0);
        accept();
        capture("busy.early", 1'b0, 2'd3, 32'hDEADBEEF);
        respond("busy.resp", 32'h1111, 2'd0);
        capture("busy.late", 1'b1, 2'd3, 32'h1111);
        dmi_reset();
        check("busy.rst.op",   64'(bus.dtm_op_o), 64'd0);
        check("busy.rst.data", 64'(bus.dtm_data_o), 64'd0);
        capture("busy.clean", 1'b0, 2'd0, 32'h0);

        // Error response makes the status sticky FAILED and blocks new requests.
        issue(7'h20, 32'h0);
        accept();
        respond("fail.resp", 32'h2222, 2'd2);
        capture("fail.cap", 1'b1, 2'd2, 32'h2222);
        issue(7'h21, 32'h0);
        check("fail.drop", 64'(bus.dm_req_valid_o), 64'd0);
        step();
        check("fail.drop2", 64'(bus.dm_req_valid_o), 64'd0);
        check("fail.hs", 64'(hs), 64'd3);
        capture("fail.keep", 1'b0, 2'd2, 32'h2222);
        dmi_reset();

        // Three back-to-back requests while the DM stalls.
        bus.dtm_req_valid_i = 1'b1;
        bus.dtm_req_i = '{addr: 7'h30, op: DMI_READ, data: 32'hA};
        step();
        bus.dtm_req_i = '{addr: 7'h31, op: DMI_WRITE, data: 32'hB};
        step();
        bus.dtm_req_i = '{addr: 7'h32, op: DMI_WRITE, data: 32'hC};
        step();
        bus.dtm_req_valid_i = 1'b0;
        check("b2b.valid", 64'(bus.dm_req_valid_o), 64'd1);
        check("b2b.addr",  64'(bus.dm_req_o.addr), 64'h30);
        step();
        check("b2b.data",  64'(bus.dm_req_o.data), 64'hA);
        accept();
        check("b2b.idle", 64'(bus.dm_req_valid_o), 64'd0);
        check("b2b.hs",   64'(hs), 64'd4);
        capture("b2b.cap", 1'b0, 2'd3, 32'h0);
        dmi_reset();

        // Fill the FIFO, refuse a third response, then drain in order.
        issue(7'h40, 32'h0);
        accept();
        issue(7'h41, 32'h0);
        accept();
        respond("full.r1", 32'hA, 2'd0);
        respond("full.r2", 32'hB, 2'd0);
        bus.dm_resp_valid_i = 1'b1;
        bus.dm_resp_i       = '{data: 32'hC, resp: 2'd0};
        #1;
        check("full.ready", 64'(bus.dm_resp_ready_o), 64'd0);
        check("full.push",  64'(bus.resp_queue_push_o), 64'd0);
        step();
        bus.dm_resp_valid_i = 1'b0;
        capture("full.c1", 1'b1, 2'd0, 32'hA);
        capture("full.c2", 1'b1, 2'd0, 32'hB);
        capture("full.c3", 1'b0, 2'd0, 32'hB);

        // Asynchronous reset in the middle of an issue.
        issue(7'h50, 32'h55);
        check("arst.pre", 64'(bus.dm_req_valid_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst.valid", 64'(bus.dm_req_valid_o), 64'd0);
        check("arst.req",   64'(bus.dm_req_o), 64'd0);
        check("arst.data",  64'(bus.dtm_data_o), 64'd0);
        #10;
        rst_ni = 1'b1;
        step();
        issue(7'h51, 32'h5151);
        check("arst.new.valid", 64'(bus.dm_req_valid_o), 64'd1);
        check("arst.new.data",  64'(bus.dm_req_o.data), 64'h5151);
        accept();
        check("arst.new.idle", 64'(bus.dm_req_valid_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmi_resp_ctrl.md
Name: dmi_resp_ctrl

Overview:
- Sequencing controller between the JTAG DTM (DMI scan register) and the Debug Module.
- Forwards DMI requests to the DM and accepts DM responses into the 2-deep DMI response FIFO (push side).
- Pops the FIFO when the DTM captures a result, and tracks outstanding operations.
- Generates the sticky "busy" (op=3) and "failed" (op=2) DMI status defined by the RISC-V debug spec. dmireset clears the sticky status.

Parameters:
- MaxOutstanding, 2, maximum requests issued but not yet popped; must be ≤ FIFO depth.
- CntW, $clog2(MaxOutstanding+1), outstanding counter width (derived, not overridable).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset; asynchronous, active-low
- dmi_rst_ni  input  1  synchronous DTM-side reset (dmireset/TLR), active-low
- dtm_req_valid_i  input  1  single-cycle pulse: update-DR with op=read/write
- dtm_req_i  input  $bits(dmi_req_t)  request (addr, op, data)
- dtm_capture_i  input  1  single-cycle pulse: capture-DR of dmi
- dtm_op_o  output  2  status captured into the dmi op field
- dtm_data_o  output  32  data captured into the dmi data field
- dm_req_valid_o  output  1  request valid to DM
- dm_req_o  output  $bits(dmi_req_t)  request to DM (registered)
- dm_req_ready_i  input  1  DM accepts request
- dm_resp_valid_i  input  1  DM response valid
- dm_resp_i  input  $bits(dmi_resp_t)  DM response
- dm_resp_ready_o  output  1  = ~resp_queue_full_i
- resp_queue_push_o  output  1  FIFO push
- resp_queue_inp_o  output  $bits(dmi_resp_t)  FIFO write data (= dm_resp_i)
- resp_queue_pop_o  output  1  FIFO pop
- resp_queue_data_i  input  $bits(dmi_resp_t)  FIFO head
- resp_queue_full_i  input  1  FIFO full
- resp_queue_empty_i  input  1  FIFO empty

Behaviour:
- Reset (rst_ni low, async) or dmi_rst_ni low (sync):
  - Request FSM goes to IDLE; outstanding count = 0; sticky = OK.
  - All outputs 0: dm_req_valid_o, dm_req_o, dtm_op_o, dtm_data_o, push, pop.
  - The FIFO is flushed externally by dmi_rst_ni.
- Request FSM states: IDLE, ISSUE.
  - IDLE → ISSUE on dtm_req_valid_i when sticky==OK and count<MaxOutstanding. dm_req_o latches dtm_req_i; count +1 in the same cycle.
  - ISSUE: dm_req_valid_o=1, dm_req_o held stable until dm_req_ready_i, then → IDLE. Latency from dtm_req_valid_i to dm_req_valid_o = 1 cycle.
  - dtm_req_valid_i while in ISSUE, while count==MaxOutstanding, or while sticky≠OK: request dropped, sticky ← BUSY (unless already FAILED).
- Response path:
  - resp_queue_push_o = dm_resp_valid_i & ~resp_queue_full_i (combinational).
  - resp_queue_inp_o = dm_resp_i.
- Capture:
  - FIFO non-empty: resp_queue_pop_o=1 for one cycle; dtm_data_o ← head.data; count −1.
  - dtm_op_o ← sticky if sticky≠OK; else head.resp (0→0, nonzero→2, and sticky ← FAILED).
  - FIFO empty and count>0: dtm_op_o ← 3, sticky ← BUSY, no pop, dtm_data_o holds.
  - FIFO empty and count==0: dtm_op_o ← sticky, dtm_data_o holds.
  - Outputs are registered and valid the cycle after dtm_capture_i.
- Simultaneous issue and pop: count is unchanged. The counter never wraps; overflow and underflow are asserted-illegal.
- Sticky is cleared only by dmi_rst_ni low. Priority: FAILED over BUSY over OK.
- Simultaneous dtm_req_valid_i and dtm_capture_i: capture is evaluated first; a request admitted in that cycle sees the updated sticky.

Decomposition:
- Existing DM package holds dmi_req_t, dmi_resp_t, and the dtm_op_e status enum (OK=0, FAILED=2, BUSY=3).
- New in package: req_state_e (IDLE, ISSUE).
- No sub-module is needed. The FIFO stays as the existing response FIFO instance, connected at the DTM top level.

Test Plan:
- Read addr 0x04: DM returns data 0xDEADBEEF, resp=0 two cycles after accept. Capture → op=0, data=0xDEADBEEF, one pop pulse, count back to 0.
- Capture before the DM responds (count=1, FIFO empty) → op=3. A later capture after the response still returns op=3 until a dmi_rst_ni pulse; after the reset the FIFO is empty and the count is 0.
- DM response with resp=2 → capture op=2 and sticky FAILED. A following request is dropped (dm_req_valid_o stays 0) and a later busy condition still reports op=2.
- Issue 3 back-to-back requests with the DM holding dm_req_ready_i=0 → the 2nd and 3rd are dropped and sticky becomes BUSY. Only one dm_req_valid_o transaction occurs, holding stable.
- Two responses with the FIFO full (no captures) → dm_resp_ready_o=0 and no push on the 3rd. Two captures return data in order, with pop on each.
- Assert rst_ni low mid-ISSUE → all outputs 0 immediately (asynchronous). After release the FSM is IDLE and a new request issues normally.
